// File: rtl/pcie_arb_pkg.sv
// Shared definitions for the PCIe RX TLP arbiter.
// Holds the arbiter state encoding, the RX sideband struct layout and the
// default sizing used by pcie_rx_tlp_arb and pcie_rr_arb.
package pcie_arb_pkg;

    localparam int PF_WIDTH       = 3;
    localparam int VF_WIDTH       = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_GAP_CYCLES = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        GAP  = 2'd2
    } t_arb_state;

    // Sideband carried alongside every beat: {bar, vf_active, pfn, vfn}.
    typedef struct packed {
        logic [2:0]          bar;
        logic                vf_active;
        logic [PF_WIDTH-1:0] pfn;
        logic [VF_WIDTH-1:0] vfn;
    } t_avst_rx_meta;

endpackage

// File: rtl/pcie_rr_arb.sv
// Combinational round-robin selector.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the previously granted requester
//   grant      - one-hot grant (all zero when nothing requests)
//   grant_idx  - index of the granted requester
//   any_grant  - at least one requester was selected
// Search starts at last_grant+1 and wraps modulo NUM_REQ.
module pcie_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    localparam int unsigned NR = NUM_REQ;

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        // Offsets 1..NR visit every requester once, last_grant itself last.
        for (int unsigned i = 1; i <= NR; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % NR);
            if (!any_grant && req[cand]) begin
                any_grant = 1'b1;
                grant_idx = cand;
            end
        end
        grant = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/pcie_rx_tlp_arb.sv
// Merges NUM_REQ Avalon-ST TLP requesters into one RX stream.
// Packet-locked round-robin arbitration with optional idle gap between TLPs.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   req_valid/sop/eop/data/empty/meta - per-requester AVST beats (packed)
//   req_ready                       - per-requester beat accept
//   out_valid/sop/eop/data/empty/meta - merged stream, one register stage
//   out_ready                       - downstream accept
//   grant_id                        - current or last granted requester
//   proto_err                       - pulse on sop seen inside a packet
//   tlp_cnt                         - forwarded eop beats, wrapping
module pcie_rx_tlp_arb
    import pcie_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_W     = 256,
    parameter int META_W     = 3 + 1 + PF_WIDTH + VF_WIDTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_sop,
    input  logic [NUM_REQ-1:0]          req_eop,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*3-1:0]        req_empty,
    input  logic [NUM_REQ*META_W-1:0]   req_meta,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic [DATA_W-1:0]           out_data,
    output logic [2:0]                  out_empty,
    output logic [META_W-1:0]           out_meta,
    input  logic                        out_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        proto_err,
    output logic [15:0]                 tlp_cnt
);

    localparam int IW = $clog2(NUM_REQ);

    t_arb_state         state;
    logic [IW-1:0]      last_grant;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [7:0]         gap_cnt;
    logic               first_beat;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    logic               accept;
    logic               sel_sop;
    logic               sel_eop;
    logic [DATA_W-1:0]  sel_data;
    logic [2:0]         sel_empty;
    logic [META_W-1:0]  sel_meta;

    // Only requesters presenting a start-of-packet compete for the grant.
    pcie_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_rr (
        .req        (req_valid & req_sop),
        .last_grant (last_grant),
        .grant      (arb_gnt),
        .grant_idx  (arb_idx),
        .any_grant  (arb_any)
    );

    always_comb begin
        req_ready = '0;
        if (state == PKT && (!out_valid || out_ready)) begin
            req_ready = gnt_oh;
        end
    end

    assign accept    = (state == PKT) && req_valid[grant_id] && req_ready[grant_id];
    assign sel_sop   = req_sop[grant_id];
    assign sel_eop   = req_eop[grant_id];
    assign sel_data  = req_data[grant_id*DATA_W +: DATA_W];
    assign sel_empty = req_empty[grant_id*3 +: 3];
    assign sel_meta  = req_meta[grant_id*META_W +: META_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            grant_id   <= '0;
            gnt_oh     <= '0;
            gap_cnt    <= '0;
            first_beat <= 1'b0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_data   <= '0;
            out_empty  <= '0;
            out_meta   <= '0;
            proto_err  <= 1'b0;
            tlp_cnt    <= '0;
        end else begin
            proto_err <= 1'b0;

            if (out_valid && out_ready && out_eop) begin
                tlp_cnt <= tlp_cnt + 16'd1;
            end

            // Output stage reloads only when empty or draining this cycle.
            if (!out_valid || out_ready) begin
                out_valid <= accept;
                if (accept) begin
                    out_sop   <= sel_sop;
                    out_eop   <= sel_eop;
                    out_data  <= sel_data;
                    out_empty <= sel_eop ? sel_empty : 3'd0;
                    out_meta  <= sel_meta;
                end
            end

            if (accept && sel_sop && !first_beat) begin
                proto_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant_id   <= arb_idx;
                        last_grant <= arb_idx;
                        gnt_oh     <= arb_gnt;
                        first_beat <= 1'b1;
                        state      <= PKT;
                    end
                end
                PKT: begin
                    if (accept) begin
                        first_beat <= 1'b0;
                        if (sel_eop) begin
                            if (GAP_CYCLES == 0) begin
                                state <= IDLE;
                            end else begin
                                gap_cnt <= 8'(GAP_CYCLES - 1);
                                state   <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_rx_tlp_arb.sv
// Directed bench for pcie_rx_tlp_arb: main instance with GAP_CYCLES=0 and a
// second instance with GAP_CYCLES=2 for gap timing.
module tb_pcie_rx_tlp_arb;
    import pcie_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int MW = 3 + 1 + PF_WIDTH + VF_WIDTH;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_sop, req_eop, req_ready;
    logic [N*DW-1:0] req_data;
    logic [N*3-1:0]  req_empty;
    logic [N*MW-1:0] req_meta;
    logic            out_valid, out_sop, out_eop, out_ready;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_empty;
    logic [MW-1:0]   out_meta;
    logic [IW-1:0]   grant_id;
    logic            proto_err;
    logic [15:0]     tlp_cnt;

    logic [N-1:0]    g_req_valid, g_req_sop, g_req_eop, g_req_ready;
    logic [N*DW-1:0] g_req_data;
    logic [N*3-1:0]  g_req_empty;
    logic [N*MW-1:0] g_req_meta;
    logic            g_out_valid, g_out_sop, g_out_eop, g_out_ready;
    logic [DW-1:0]   g_out_data;
    logic [2:0]      g_out_empty;
    logic [MW-1:0]   g_out_meta;
    logic [IW-1:0]   g_grant_id;
    logic            g_proto_err;
    logic [15:0]     g_tlp_cnt;

    pcie_rx_tlp_arb #(.NUM_REQ(N), .DATA_W(DW), .META_W(MW), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop),
        .req_data(req_data), .req_empty(req_empty), .req_meta(req_meta),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .out_empty(out_empty), .out_meta(out_meta),
        .out_ready(out_ready), .grant_id(grant_id), .proto_err(proto_err),
        .tlp_cnt(tlp_cnt)
    );

    pcie_rx_tlp_arb #(.NUM_REQ(N), .DATA_W(DW), .META_W(MW), .GAP_CYCLES(2)) dut_gap (
        .clk(clk), .rst_n(rst_n),
        .req_valid(g_req_valid), .req_sop(g_req_sop), .req_eop(g_req_eop),
        .req_data(g_req_data), .req_empty(g_req_empty), .req_meta(g_req_meta),
        .req_ready(g_req_ready),
        .out_valid(g_out_valid), .out_sop(g_out_sop), .out_eop(g_out_eop),
        .out_data(g_out_data), .out_empty(g_out_empty), .out_meta(g_out_meta),
        .out_ready(g_out_ready), .grant_id(g_grant_id), .proto_err(g_proto_err),
        .tlp_cnt(g_tlp_cnt)
    );

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [31:0] tag;
    } beat_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [31:0] tag;
        logic        data_ok;
        logic        meta_ok;
        logic [31:0] cyc;
    } obeat_t;

    beat_t       rbuf [N][16];
    int unsigned rhead [N];
    int unsigned rtail [N];
    obeat_t      obuf [64];
    obeat_t      gbuf [8];
    int unsigned ocnt, gcnt, pe_cnt, stab_err, stall_cnt, base;
    logic [31:0] cyc;
    logic        rdy_toggle;
    int          n_pass, n_checks, n_fail;
    logic [31:0] exp_tag [8];
    logic [2:0]  exp_emp [8];
    logic        exp_sop [8];
    logic        exp_eop [8];

    function automatic logic [31:0] mk(input int r, input int t, input int b);
        return 32'((r << 16) | (t << 8) | b);
    endfunction

    function automatic logic [MW-1:0] meta_of(input logic [31:0] tag);
        return tag[MW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic s, input logic e,
                        input logic [2:0] emp, input logic [31:0] tag);
        rbuf[r][rtail[r] % 16] = '{sop: s, eop: e, empty: emp, tag: tag};
        rtail[r]++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_beats(input string name, input int unsigned n, input int budget);
        int k;
        k = 0;
        while (ocnt < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #3;
        chk(name, 32'(ocnt >= n), 32'd1);
    endtask

    task automatic chk_beat(input string name, input int unsigned idx, input logic [31:0] tag,
                            input logic s, input logic e, input logic [2:0] emp);
        chk({name, "_tag"},   obuf[idx].tag, tag);
        chk({name, "_sop"},   32'(obuf[idx].sop), 32'(s));
        chk({name, "_eop"},   32'(obuf[idx].eop), 32'(e));
        chk({name, "_empty"}, 32'(obuf[idx].empty), 32'(emp));
        chk({name, "_data"},  32'(obuf[idx].data_ok & obuf[idx].meta_ok), 32'd1);
    endtask

    // Requester drivers: present head of each queue, pop on accepted beat.
    initial begin
        logic [N-1:0] acc;
        beat_t b;
        req_valid = '0; req_sop = '0; req_eop = '0;
        req_data = '0; req_empty = '0; req_meta = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            out_ready = rdy_toggle ? ~out_ready : 1'b1;
            for (int r = 0; r < N; r++) begin
                if (acc[r] && rhead[r] != rtail[r]) rhead[r]++;
                if (rhead[r] != rtail[r]) begin
                    b = rbuf[r][rhead[r] % 16];
                    req_valid[r]             = 1'b1;
                    req_sop[r]               = b.sop;
                    req_eop[r]               = b.eop;
                    req_empty[r*3 +: 3]      = b.empty;
                    req_data[r*DW +: DW]     = {8{b.tag}};
                    req_meta[r*MW +: MW]     = meta_of(b.tag);
                end else begin
                    req_valid[r] = 1'b0;
                    req_sop[r]   = 1'b0;
                    req_eop[r]   = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 32'd1;
    end

    // Output monitor, sampled mid-cycle.
    initial begin
        logic stalled_prev;
        logic [DW+MW+5:0] held;
        stalled_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && out_ready && ocnt < 64) begin
                    obuf[ocnt] = '{sop: out_sop, eop: out_eop, empty: out_empty,
                                   tag: out_data[31:0],
                                   data_ok: (out_data === {8{out_data[31:0]}}),
                                   meta_ok: (out_meta === out_data[MW-1:0]), cyc: cyc};
                    ocnt++;
                end
                if (proto_err) pe_cnt++;
                if (stalled_prev &&
                    {out_valid, out_sop, out_eop, out_empty, out_meta, out_data} !== held)
                    stab_err++;
                stalled_prev = out_valid && !out_ready;
                if (stalled_prev) stall_cnt++;
                held = {out_valid, out_sop, out_eop, out_empty, out_meta, out_data};
                if (g_out_valid && g_out_ready && gcnt < 8) begin
                    gbuf[gcnt] = '{sop: g_out_sop, eop: g_out_eop, empty: g_out_empty,
                                   tag: g_out_data[31:0], data_ok: 1'b1, meta_ok: 1'b1, cyc: cyc};
                    gcnt++;
                end
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gacc;
        int   gi;
        n_pass = 0; n_checks = 0; n_fail = 0;
        ocnt = 0; gcnt = 0; pe_cnt = 0; stab_err = 0; stall_cnt = 0;
        cyc = '0; rdy_toggle = 1'b0;
        for (int r = 0; r < N; r++) begin rhead[r] = 0; rtail[r] = 0; end
        g_req_valid = '0; g_req_sop = '0; g_req_eop = '0;
        g_req_data = '0; g_req_empty = '0; g_req_meta = '0; g_out_ready = 1'b1;
        rst_n = 1'b0;

        // Reset state
        wait_cycles(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tlp_cnt",   32'(tlp_cnt), 32'd0);
        chk("rst_grant_id",  32'(grant_id), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_out_data",  32'(out_data == '0), 32'd1);
        chk("rst_out_meta",  32'(out_meta), 32'd0);
        rst_n = 1'b1;
        wait_cycles(2);

        // Four simultaneous single-beat TLPs -> order 0,1,2,3
        base = ocnt;
        for (int r = 0; r < N; r++) push(r, 1'b1, 1'b1, 3'(r), mk(r, 1, 0));
        wait_beats("a_timeout", base + 4, 40);
        for (int r = 0; r < N; r++) chk_beat("a_beat", base + r, mk(r, 1, 0), 1'b1, 1'b1, 3'(r));
        chk("a_spacing", obuf[base+1].cyc - obuf[base].cyc, 32'd2);
        wait_cycles(2);
        chk("a_tlp_cnt", 32'(tlp_cnt), 32'd4);
        chk("a_grant_id", 32'(grant_id), 32'd3);

        // Req1 3-beat TLP, req2 sop arrives mid-packet
        base = ocnt;
        push(1, 1'b1, 1'b0, 3'd7, mk(1, 2, 0));
        push(1, 1'b0, 1'b0, 3'd7, mk(1, 2, 1));
        push(1, 1'b0, 1'b1, 3'd4, mk(1, 2, 2));
        wait_cycles(2);
        push(2, 1'b1, 1'b0, 3'd7, mk(2, 2, 0));
        push(2, 1'b0, 1'b1, 3'd2, mk(2, 2, 1));
        exp_tag[0] = mk(1, 2, 0); exp_sop[0] = 1; exp_eop[0] = 0; exp_emp[0] = 0;
        exp_tag[1] = mk(1, 2, 1); exp_sop[1] = 0; exp_eop[1] = 0; exp_emp[1] = 0;
        exp_tag[2] = mk(1, 2, 2); exp_sop[2] = 0; exp_eop[2] = 1; exp_emp[2] = 4;
        exp_tag[3] = mk(2, 2, 0); exp_sop[3] = 1; exp_eop[3] = 0; exp_emp[3] = 0;
        exp_tag[4] = mk(2, 2, 1); exp_sop[4] = 0; exp_eop[4] = 1; exp_emp[4] = 2;
        wait_beats("b_timeout", base + 5, 60);
        for (int i = 0; i < 5; i++)
            chk_beat("b_beat", base + i, exp_tag[i], exp_sop[i], exp_eop[i], exp_emp[i]);
        chk("b_contiguous", obuf[base+2].cyc - obuf[base].cyc, 32'd2);
        wait_cycles(2);
        chk("b_tlp_cnt", 32'(tlp_cnt), 32'd6);

        // out_ready toggling during a 4-beat TLP
        base = ocnt; stab_err = 0; stall_cnt = 0;
        rdy_toggle = 1'b1;
        push(0, 1'b1, 1'b0, 3'd0, mk(0, 3, 0));
        push(0, 1'b0, 1'b0, 3'd0, mk(0, 3, 1));
        push(0, 1'b0, 1'b0, 3'd0, mk(0, 3, 2));
        push(0, 1'b0, 1'b1, 3'd3, mk(0, 3, 3));
        wait_beats("c_timeout", base + 4, 80);
        rdy_toggle = 1'b0;
        wait_cycles(5);
        for (int i = 0; i < 4; i++)
            chk_beat("c_beat", base + i, mk(0, 3, i), 1'(i == 0), 1'(i == 3), (i == 3) ? 3'd3 : 3'd0);
        chk("c_no_dup", ocnt - base, 32'd4);
        chk("c_stalls_seen", 32'(stall_cnt > 0), 32'd1);
        chk("c_stable", stab_err, 32'd0);
        chk("c_tlp_cnt", 32'(tlp_cnt), 32'd7);

        // Req3 raises sop on 2nd beat -> one proto_err pulse, beat forwarded
        base = ocnt; pe_cnt = 0;
        push(3, 1'b1, 1'b0, 3'd0, mk(3, 4, 0));
        push(3, 1'b1, 1'b0, 3'd0, mk(3, 4, 1));
        push(3, 1'b0, 1'b0, 3'd0, mk(3, 4, 2));
        push(3, 1'b0, 1'b1, 3'd0, mk(3, 4, 3));
        wait_beats("d_timeout", base + 4, 40);
        wait_cycles(2);
        chk("d_proto_err_pulses", pe_cnt, 32'd1);
        chk_beat("d_beat1", base + 1, mk(3, 4, 1), 1'b1, 1'b0, 3'd0);
        chk("d_tlp_cnt", 32'(tlp_cnt), 32'd8);

        // Reset mid-packet at beat 2 of 4
        base = ocnt;
        for (int b = 0; b < 4; b++) push(3, 1'(b == 0), 1'(b == 3), 3'd0, mk(3, 5, b));
        wait_beats("e_timeout", base + 2, 40);
        rst_n = 1'b0;
        #1;
        chk("e_out_valid", 32'(out_valid), 32'd0);
        chk("e_out_flags", 32'({out_sop, out_eop, out_empty}), 32'd0);
        chk("e_out_data",  32'(out_data == '0), 32'd1);
        chk("e_out_meta",  32'(out_meta), 32'd0);
        chk("e_req_ready", 32'(req_ready), 32'd0);
        chk("e_tlp_cnt",   32'(tlp_cnt), 32'd0);
        chk("e_grant_id",  32'(grant_id), 32'd0);
        for (int r = 0; r < N; r++) rhead[r] = rtail[r];
        wait_cycles(2);
        rst_n = 1'b1;
        base = ocnt;
        push(3, 1'b1, 1'b1, 3'd1, mk(3, 6, 0));
        push(0, 1'b1, 1'b1, 3'd1, mk(0, 6, 0));
        wait_beats("e2_timeout", base + 2, 40);
        wait_cycles(3);
        chk("e2_count", ocnt - base, 32'd2);
        chk("e2_first", obuf[base].tag, mk(0, 6, 0));
        chk("e2_second", obuf[base+1].tag, mk(3, 6, 0));
        chk("e2_tlp_cnt", 32'(tlp_cnt), 32'd2);

        // GAP_CYCLES=2 instance: back-to-back single-beat TLPs from req0
        gi = 0;
        g_req_valid[0] = 1'b1; g_req_sop[0] = 1'b1; g_req_eop[0] = 1'b1;
        g_req_empty[2:0] = 3'd5;
        g_req_data[DW-1:0] = {8{mk(0, 7, 0)}};
        for (int k = 0; k < 40 && gi < 2; k++) begin
            @(negedge clk);
            gacc = g_req_valid[0] & g_req_ready[0];
            @(posedge clk);
            #1;
            if (gacc) begin
                gi++;
                if (gi < 2) g_req_data[DW-1:0] = {8{mk(0, 7, 1)}};
                else        g_req_valid[0] = 1'b0;
            end
        end
        wait_cycles(4);
        chk("f_count", gcnt, 32'd2);
        chk("f_tag0", gbuf[0].tag, mk(0, 7, 0));
        chk("f_tag1", gbuf[1].tag, mk(0, 7, 1));
        chk("f_gap_spacing", gbuf[1].cyc - gbuf[0].cyc, 32'd4);
        chk("f_empty", 32'(gbuf[1].empty), 32'd5);
        chk("f_tlp_cnt", 32'(g_tlp_cnt), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pcie_rx_tlp_arb.md
PCIE_RX_TLP_ARB -- requirements
Module: pcie_rx_tlp_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, 4, number of AVST TLP requesters (2..8).
REQ-002 SHALL have parameter DATA_W, 256, AVST data width in bits (8 DW per beat).
REQ-003 SHALL have parameter META_W, 3+1+PF_WIDTH+VF_WIDTH, sideband width carrying {bar, vf_active, pfn, vfn}.
REQ-004 SHALL have parameter GAP_CYCLES, 0, idle cycles forced between consecutive TLPs (0..255).
REQ-005 SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid / req_sop / req_eop  in  NUM_REQ each  per-requester beat qualifiers.
REQ-008 SHALL have port req_data  in  NUM_REQ*DATA_W  per-requester beat data.
REQ-009 SHALL have port req_empty  in  NUM_REQ*3  per-requester empty DW count, valid on eop.
REQ-010 SHALL have port req_meta  in  NUM_REQ*META_W  per-requester sideband, sampled on every accepted beat.
REQ-011 SHALL have port req_ready  out  NUM_REQ  per-requester beat accept.
REQ-012 SHALL have ports out_valid/out_sop/out_eop (1 each), out_data (DATA_W), out_empty (3), out_meta (META_W), all outputs: the merged AVST RX stream.
REQ-013 SHALL have port out_ready  in  1  downstream accept.
REQ-014 SHALL have port grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
REQ-015 SHALL have port proto_err  out  1  one-cycle pulse on protocol violation.
REQ-016 SHALL have port tlp_cnt  out  16  count of forwarded eop beats, wraps 0xFFFF->0.

Function
REQ-017 SHALL implement states IDLE, PKT, GAP.
REQ-018 IDLE: SHALL grant the first requester with req_valid&req_sop, round-robin starting at last_grant+1 modulo NUM_REQ; grant registered, state->PKT next cycle; req_ready all 0 in IDLE.
REQ-019 IDLE: requester with req_valid but not req_sop SHALL never be granted and SHALL not raise proto_err.
REQ-020 PKT: req_ready[grant]=(~out_valid | out_ready); all other req_ready 0.
REQ-021 Accepted beat (req_valid&req_ready) at cycle t SHALL appear on out_* at t+1 (one register stage); out_* SHALL hold stable while out_valid&~out_ready.
REQ-022 Grant SHALL be packet-locked: no re-arbitration until the granted requester's eop beat is accepted.
REQ-023 Accepted eop: GAP_CYCLES==0 -> IDLE; else -> GAP, counting exactly GAP_CYCLES cycles, then IDLE.
REQ-024 Single-beat TLP (sop&eop same beat) SHALL be legal and follow REQ-023.
REQ-025 PKT: accepted beat with sop=1 after the first beat SHALL pulse proto_err and still be forwarded unchanged.
REQ-026 out_empty SHALL be forced to 0 on non-eop beats.
REQ-027 tlp_cnt SHALL increment when out_valid&out_ready&out_eop.
REQ-028 Minimum TLP-to-TLP overhead with GAP_CYCLES=0: one IDLE cycle between eop accept and next sop accept.

Reset
REQ-029 On rst_n low: state=IDLE, out_valid=0, out_sop=0, out_eop=0, out_data=0, out_empty=0, out_meta=0, req_ready=0, proto_err=0, tlp_cnt=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 highest priority after reset).
REQ-030 Reset asserted mid-packet SHALL discard the in-flight TLP; no partial beats emitted after deassertion.

Structure
REQ-031 Shared package pcie_arb_pkg SHALL hold t_arb_state enum, t_avst_rx_meta struct {bar[2:0], vf_active, pfn, vfn}, and NUM_REQ/GAP_CYCLES defaults.
REQ-032 Round-robin selection SHALL be a sub-module pcie_rr_arb (inputs: request vector, last_grant; outputs: grant one-hot, grant index, any_grant), purely combinational.

Verification
REQ-033 NUM_REQ=4, all four present 1-beat TLPs at once, out_ready=1 -> out order 0,1,2,3; tlp_cnt=4.
REQ-034 Req1 sends 3-beat TLP (length 20 DW, empty=4 on eop), req2 sop asserted mid-packet -> req2 beats only after req1 eop; req1 beats contiguous on out; out_empty=4 on eop only.
REQ-035 out_ready toggles 1/0 every cycle during 4-beat TLP -> no beat lost/duplicated, out_* stable while stalled.
REQ-036 GAP_CYCLES=2, back-to-back TLPs from req0 -> exactly 2 GAP + 1 IDLE cycle between eop and next sop on out.
REQ-037 Req3 asserts sop on 2nd beat -> proto_err pulses once, beat forwarded; rst_n low at beat 2 of 4 -> all outputs 0, next sop from req0 granted first.
